// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-level debounce; emits one ready strobe per accepted press.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 50,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] tecla,
  output logic       ready,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'd1;   4'h1: key_code = 4'd2;   4'h2: key_code = 4'd3;   4'h3: key_code = 4'd10;
      4'h4: key_code = 4'd4;   4'h5: key_code = 4'd5;   4'h6: key_code = 4'd6;   4'h7: key_code = 4'd11;
      4'h8: key_code = 4'd7;   4'h9: key_code = 4'd8;   4'hA: key_code = 4'd9;   4'hB: key_code = 4'd12;
      4'hC: key_code = 4'd14;  4'hD: key_code = 4'd0;   4'hE: key_code = 4'd15;  default: key_code = 4'd13;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [1:0]       acc_hits_q, acc_hits_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [3:0]       tecla_q, tecla_d;
  logic             ready_q, ready_d;
  logic             key_down_q, key_down_d;

  logic             sample_en, scan_done;
  logic [3:0]       row_hit;
  logic [2:0]       col_hits, sum_hits;
  logic [1:0]       col_row, scan_hits;
  logic [3:0]       scan_code;
  logic [CNT_W-1:0] cnt_inc, rcnt_inc;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
`endif

  // Rows are read directly at the last cycle of each column window, giving them SCAN_DIV-1 cycles to settle.
  assign row_hit   = ~row_in;
  assign sample_en = (div_cnt_q == DIV_LAST);
  assign scan_done = sample_en && (col_idx_q == 2'd3);
  assign cnt_inc   = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + CNT_ONE;
  assign rcnt_inc  = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_ONE;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_hit[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    sum_hits  = {1'b0, acc_hits_q} + (sample_en ? col_hits : 3'd0);
    scan_hits = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
    scan_code = (acc_hits_q != 2'd0) ? acc_code_q : key_code(col_row, col_idx_q);
  end

  always_comb begin
    div_cnt_d  = sample_en ? '0 : div_cnt_q + DIV_W'(1);
    col_idx_d  = sample_en ? col_idx_q + 2'd1 : col_idx_q;
    col_out_d  = ~(4'b0001 << col_idx_d);
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (scan_done) begin
      acc_hits_d = 2'd0;
      acc_code_d = 4'd0;
    end else if (sample_en) begin
      acc_hits_d = scan_hits;
      acc_code_d = scan_code;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    tecla_d    = tecla_q;
    ready_d    = 1'b0;
    key_down_d = key_down_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_inc    = (rep_cnt_q == REP_MAX) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
`endif
    if (scan_done) begin
      unique case (state_q)
        IDLE: if (scan_hits == 2'd1) begin
          cand_d = scan_code;
          cnt_d  = CNT_ONE;
          if (DEBOUNCE_SCANS == 1) begin
            state_d    = PRESSED;
            tecla_d    = scan_code;
            ready_d    = 1'b1;
            key_down_d = 1'b1;
          end else begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (scan_hits == 2'd1 && scan_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d    = PRESSED;
              tecla_d    = cand_q;
              ready_d    = 1'b1;
              key_down_d = 1'b1;
            end
          end else if (scan_hits == 2'd1) begin
            cand_d = scan_code;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: if (scan_hits == 2'd0) begin
          rcnt_d = CNT_ONE;
          if (DEBOUNCE_SCANS == 1) begin
            state_d    = IDLE;
            key_down_d = 1'b0;
          end else begin
            state_d = RELEASE;
          end
        end
        default: begin
          if (scan_hits == 2'd0) begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc == CNT_MAX) begin
              state_d    = IDLE;
              key_down_d = 1'b0;
            end
          end else begin
            state_d = PRESSED;
          end
        end
      endcase
`ifdef KEY_REPEAT_EN
      // Only a scan that keeps us in PRESSED on the accepted key advances the repeat count.
      if (state_q == PRESSED && state_d == PRESSED && scan_hits == 2'd1 && scan_code == tecla_q) begin
        rep_cnt_d = rep_inc;
        if (rep_inc == REP_MAX) begin
          rep_cnt_d = '0;
          ready_d   = 1'b1;
        end
      end else begin
        rep_cnt_d = '0;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      col_idx_q  <= 2'd0;
      col_out_q  <= 4'b1110;
      acc_hits_q <= 2'd0;
      acc_code_q <= 4'd0;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      tecla_q    <= 4'd0;
      ready_q    <= 1'b0;
      key_down_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      col_idx_q  <= col_idx_d;
      col_out_q  <= col_out_d;
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      tecla_q    <= tecla_d;
      ready_q    <= ready_d;
      key_down_q <= key_down_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign col_out  = col_out_q;
  assign tecla    = tecla_q;
  assign ready    = ready_q;
  assign key_down = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a matrix model drives row_in, a scoreboard of expected
// ready strobes (key code and clock edge) is filled at stimulus time and drained by a monitor.
module tb_keypad_scanner;

  localparam int SCAN_CYC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] tecla;
  logic       ready;
  logic       key_down;

  logic [15:0] pressed;
  int          edges;
  int          errors = 0;
  int          checks = 0;
  int          pulse_cnt = 0;
  int          exp_total = 0;
  logic        prev_ready = 1'b0;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] at_edge;
  } exp_t;
  exp_t sb[$];

  keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .tecla    (tecla),
    .ready    (ready),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ready(input logic [3:0] code, input int scans_ahead);
    exp_t e;
    e.code    = code;
    e.at_edge = 32'(edges + SCAN_CYC * scans_ahead);
    sb.push_back(e);
    exp_total++;
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN_CYC) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_out"},  32'(col_out),  32'(4'b1110));
    check({tag, "_tecla"},    32'(tecla),    32'(0));
    check({tag, "_ready"},    32'(ready),    32'(0));
    check({tag, "_key_down"}, 32'(key_down), 32'(0));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (ready === 1'b1) begin
      pulse_cnt++;
      check("ready_back_to_back", 32'(prev_ready), 32'(0));
      check("ready_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ready_tecla", 32'(tecla), 32'(e.code));
        check("ready_edge", 32'(edges), e.at_edge);
      end
    end
    prev_ready = ready;
  end

  initial begin
    logic [3:0] exp_col;
    logic [3:0] seq_code [4];
    int         seq_idx  [4];
    seq_code = '{4'd7, 4'd10, 4'd3, 4'd13};
    seq_idx  = '{8, 3, 2, 15};

    reset   = 1'b1;
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and column walk.
    check_reset_values("reset");
    for (int i = 0; i < 8; i++) begin
      exp_col = ~(4'b0001 << (i / 2));
      check("col_walk", 32'(col_out), 32'(exp_col));
      @(negedge clk);
    end

    // Idle keypad: no strobes over 50 scans.
    wait_scans(50);
    check("idle_no_ready", 32'(pulse_cnt), 32'(0));

    // Hold '6' (r1,c2) for 20 scans.
    pressed = 16'(1) << 6;
    expect_ready(4'd6, 3);
`ifdef KEY_REPEAT_EN
    for (int k = 7; k <= 19; k += 4) expect_ready(4'd6, k);
`endif
    wait_scans(2);
    check("hold6_key_down_pre", 32'(key_down), 32'(0));
    repeat (18) begin
      wait_scans(1);
      check("hold6_key_down", 32'(key_down), 32'(1));
    end
    pressed = '0;
    wait_scans(2);
    check("rel6_key_down_2", 32'(key_down), 32'(1));
    wait_scans(1);
    check("rel6_key_down_3", 32'(key_down), 32'(0));
    check("rel6_tecla_hold", 32'(tecla), 32'(6));
    check("hold6_sb_empty", 32'(sb.size()), 32'(0));
    wait_scans(2);

    // Bouncy '5': 2 scans pressed, 1 open, 3 pressed.
    pressed = 16'(1) << 5;
    wait_scans(2);
    pressed = '0;
    wait_scans(1);
    pressed = 16'(1) << 5;
    expect_ready(4'd5, 3);
    wait_scans(3);
    pressed = '0;
    wait_scans(5);
    check("bounce5_tecla", 32'(tecla), 32'(5));
    check("bounce5_sb_empty", 32'(sb.size()), 32'(0));

    // '1'+'2' together: no acceptance; then '1' alone is accepted.
    pressed = 16'b11;
    wait_scans(5);
    check("multi_key_down", 32'(key_down), 32'(0));
    check("multi_tecla", 32'(tecla), 32'(5));
    pressed = 16'b01;
    expect_ready(4'd1, 3);
    wait_scans(3);
    pressed = '0;
    wait_scans(5);
    check("single1_tecla", 32'(tecla), 32'(1));

    // Sequence 7, A, 3, D.
    for (int k = 0; k < 4; k++) begin
      pressed = 16'(1) << seq_idx[k];
      expect_ready(seq_code[k], 3);
      wait_scans(5);
      pressed = '0;
      wait_scans(2);
      check("seq_tecla_hold", 32'(tecla), 32'(seq_code[k]));
      wait_scans(3);
    end
    check("seq_sb_empty", 32'(sb.size()), 32'(0));

    // '9' accepted, then a one-cycle reset while still held.
    pressed = 16'(1) << 10;
    expect_ready(4'd9, 3);
    wait_scans(4);
    check("pre_reset_key_down", 32'(key_down), 32'(1));
    check("pre_reset_tecla", 32'(tecla), 32'(9));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    expect_ready(4'd9, 3);
`ifdef KEY_REPEAT_EN
    expect_ready(4'd9, 7);
    expect_ready(4'd9, 11);
`endif
    wait_scans(12);
    check("post_reset_key_down", 32'(key_down), 32'(1));
    pressed = '0;
    wait_scans(5);
    check("post_reset_tecla", 32'(tecla), 32'(9));
    check("final_sb_empty", 32'(sb.size()), 32'(0));
    check("final_pulse_count", 32'(pulse_cnt), 32'(exp_total));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
